// File: rtl/svc_uart_rx.sv
// ---------------------------------------------------------------------------
// svc_uart_rx
//
// 8N1 UART receiver. Deserializes an asynchronous serial line into bytes and
// hands them out through a single-entry valid/ready buffer. Stop-bit errors
// and dropped bytes are reported as one-cycle pulses.
//
// Parameters
//   CLOCK_FREQ     system clock frequency in Hz
//   BAUD_RATE      line rate in bit/s
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   urx_in         serial line, asynchronous to clk, idles high
//   urx_valid      a received byte is waiting in the buffer
//   urx_data       the received byte, stable while urx_valid is high
//   urx_ready      consumer takes the byte when urx_valid && urx_ready
//   urx_frame_err  one-cycle pulse when a stop bit is sampled low
//   urx_overrun    one-cycle pulse when a completed byte had to be dropped
// ---------------------------------------------------------------------------
module svc_uart_rx #(
    parameter int CLOCK_FREQ = 25_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       urx_in,
    output logic       urx_valid,
    output logic [7:0] urx_data,
    input  logic       urx_ready,
    output logic       urx_frame_err,
    output logic       urx_overrun
);

    localparam int DIV   = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);

    // The start state only runs to mid-bit so that every later sample falls
    // in the middle of its bit; the other timed states run a full bit.
    localparam logic [CNT_W-1:0] LIM_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] LIM_BIT  = CNT_W'(DIV - 1);

    // With fewer than four clocks per bit there is no meaningful mid-bit.
    if (DIV < 4) begin : g_bad_div
        $error("svc_uart_rx: CLOCK_FREQ / BAUD_RATE must be at least 4");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tick;
    logic             sample_bit;
    logic             byte_done;
    logic             stop_bad;

    // Two-flop synchronizer. Both flops reset high so that reset looks like
    // an idle line and never fakes a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= urx_in;
            rx_s    <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A tick marks the sampling cycle of the current state;
    // all line decisions are taken on the synchronized value only.
    always_comb begin
        state_next = state;
        tick       = 1'b0;
        sample_bit = 1'b0;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                tick = (cnt == LIM_HALF);
                if (tick) begin
                    // Line already high again at mid start bit: a glitch.
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                tick = (cnt == LIM_BIT);
                if (tick) begin
                    sample_bit = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                tick = (cnt == LIM_BIT);
                if (tick) begin
                    if (rx_s) begin
                        byte_done  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) must not retrigger a new frame.
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bit timer. Restarts from zero on every state change and on every tick,
    // so each timed state measures its own interval from entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((state_next != state) || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Data shifter. Bits arrive LSB first, so each new bit enters at the top
    // and the first bit ends up in bit 0 after eight shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (state != ST_DATA) begin
                bit_idx <= 3'd0;
            end else if (sample_bit) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (sample_bit) begin
                shift <= {rx_s, shift[7:1]};
            end
        end
    end

    // Single-entry output buffer. A completed byte is taken if the buffer is
    // empty or is being emptied in the same cycle; otherwise the new byte is
    // the one dropped, so the consumer always sees the oldest data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            urx_valid <= 1'b0;
            urx_data  <= 8'h00;
        end else if (byte_done && (!urx_valid || urx_ready)) begin
            urx_valid <= 1'b1;
            urx_data  <= shift;
        end else if (urx_valid && urx_ready) begin
            urx_valid <= 1'b0;
        end
    end

    // Registered status pulses, high for the one cycle after the stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            urx_frame_err <= 1'b0;
            urx_overrun   <= 1'b0;
        end else begin
            urx_frame_err <= stop_bad;
            urx_overrun   <= byte_done && urx_valid && !urx_ready;
        end
    end

endmodule
